// File: rtl/xxhash32_pkg.sv
// Shared word/count widths and state encoding for the xxHash32 sequencer.
package xxhash32_pkg;

    localparam int WORD_SIZE = 32;
    localparam int COUNT_W   = 16;

    typedef enum logic [2:0] {
        IDLE,
        SEED,
        FEED,
        REQ,
        DONE
    } seq_state_e;

endpackage

// File: rtl/xxhash32_sequencer.sv
// Drives an xxHash32 core through seed / word feed / hash request for one
// command at a time, with a bounded wait for the core's result.
module xxhash32_sequencer
    import xxhash32_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [WORD_SIZE-1:0] cmd_seed,
    input  logic [COUNT_W-1:0]   cmd_count,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WORD_SIZE-1:0] in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WORD_SIZE-1:0] out_hash,
    output logic                 out_error,
    output logic                 core_seed_in,
    output logic                 core_add_to_hash,
    output logic                 core_request_hash,
    output logic [WORD_SIZE-1:0] core_input_bytes,
    input  logic                 core_hash_ready,
    input  logic [WORD_SIZE-1:0] core_output_hash
);

    localparam int               TMO_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    seq_state_e         state;
    logic [COUNT_W-1:0] remaining;
    logic [TMO_W-1:0]   tmo_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state             <= IDLE;
            remaining         <= '0;
            tmo_cnt           <= '0;
            cmd_ready         <= 1'b1;
            in_ready          <= 1'b0;
            out_valid         <= 1'b0;
            out_hash          <= '0;
            out_error         <= 1'b0;
            core_seed_in      <= 1'b0;
            core_add_to_hash  <= 1'b0;
            core_request_hash <= 1'b0;
            core_input_bytes  <= '0;
        end else begin
            core_seed_in     <= 1'b0;
            core_add_to_hash <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        cmd_ready        <= 1'b0;
                        remaining        <= cmd_count;
                        core_seed_in     <= 1'b1;
                        core_input_bytes <= cmd_seed;
                        state            <= SEED;
                    end
                end
                SEED: begin
                    tmo_cnt <= '0;
                    if (remaining == '0) begin
                        state <= REQ;
                    end else begin
                        in_ready <= 1'b1;
                        state    <= FEED;
                    end
                end
                FEED: begin
                    // in_ready is only ever high with remaining > 0, so no underflow
                    if (in_valid && in_ready) begin
                        core_add_to_hash <= 1'b1;
                        core_input_bytes <= in_data;
                        remaining        <= remaining - 1'b1;
                        if (remaining == COUNT_W'(1)) begin
                            in_ready <= 1'b0;
                            tmo_cnt  <= '0;
                            state    <= REQ;
                        end
                    end
                end
                REQ: begin
                    // request rises one cycle after entry so it never overlaps the last add pulse
                    if (core_request_hash && core_hash_ready) begin
                        core_request_hash <= 1'b0;
                        out_hash          <= core_output_hash;
                        out_error         <= 1'b0;
                        out_valid         <= 1'b1;
                        state             <= DONE;
                    end else if (tmo_cnt == TMO_LAST) begin
                        core_request_hash <= 1'b0;
                        out_hash          <= '0;
                        out_error         <= 1'b1;
                        out_valid         <= 1'b1;
                        state             <= DONE;
                    end else begin
                        core_request_hash <= 1'b1;
                        tmo_cnt           <= tmo_cnt + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        cmd_ready <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/xxhash32_sequencer.md
XXHASH32_SEQUENCER -- requirements
Module: xxhash32_sequencer

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 1024, meaning the maximum cycles in WAIT before the sequencer aborts.
REQ-002 SHALL have port clk, input, 1 bit: single clock; all logic is on the rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: synchronous, active-low reset.
REQ-004 SHALL have port cmd_valid, input, 1 bit: a start command is offered.
REQ-005 SHALL have port cmd_ready, output, 1 bit: the command is accepted when both cmd_valid and cmd_ready are high.
REQ-006 SHALL have port cmd_seed, input, 32 bits: the hash seed.
REQ-007 SHALL have port cmd_count, input, 16 bits: the number of 32-bit words in the message.
REQ-008 SHALL have port in_valid, input, 1 bit: a data word is offered.
REQ-009 SHALL have port in_ready, output, 1 bit: the word is accepted when both in_valid and in_ready are high.
REQ-010 SHALL have port in_data, input, 32 bits: the message word.
REQ-011 SHALL have port out_valid, output, 1 bit: a result is presented.
REQ-012 SHALL have port out_ready, input, 1 bit: the consumer accepts the result.
REQ-013 SHALL have port out_hash, output, 32 bits: the hash result.
REQ-014 SHALL have port out_error, output, 1 bit: the result is a timeout abort.
REQ-015 SHALL have core-side outputs core_seed_in, core_add_to_hash and core_request_hash (1 bit each) and core_input_bytes (32 bits), all registered.
REQ-016 SHALL have core-side inputs core_hash_ready (1 bit) and core_output_hash (32 bits).

Function
REQ-017 SHALL use states IDLE, SEED, FEED, REQ, DONE.
REQ-018 IDLE: cmd_ready=1; on cmd handshake SHALL latch seed and count, then go to SEED.
REQ-019 SEED, one cycle: core_seed_in=1 and core_input_bytes=seed; next state SHALL be FEED, or REQ if count==0.
REQ-020 FEED: in_ready=1 while remaining>0; each in handshake at cycle T SHALL produce core_add_to_hash=1 with core_input_bytes=in_data at T+1, and SHALL decrement remaining.
REQ-021 FEED cycles without a handshake SHALL drive core_add_to_hash=0; gaps are legal and the core holds its state.
REQ-022 When the handshake that makes remaining reach 0 occurs, the next state SHALL be REQ, with in_ready=0 from that next cycle.
REQ-023 REQ: core_request_hash=1 is held until core_hash_ready=1 is sampled; then out_hash<=core_output_hash, out_error<=0, next state DONE.
REQ-024 REQ SHALL count cycles; reaching TIMEOUT_CYCLES without core_hash_ready SHALL set out_hash=0 and out_error=1, then go to DONE.
REQ-025 DONE: out_valid=1 and out_hash/out_error SHALL be held stable until out_ready=1; then go to IDLE, with cmd_ready=1 on the following cycle.
REQ-026 At most one of core_seed_in, core_add_to_hash and core_request_hash SHALL be high in any cycle.
REQ-027 cmd_valid outside IDLE and in_valid outside FEED SHALL be ignored, with no data loss or side effect.
REQ-028 The remaining counter SHALL be 16-bit unsigned and SHALL never underflow; count 0xFFFF SHALL be supported.

Reset
REQ-029 rst_n=0 at a clock edge, in any state, SHALL force IDLE and clear remaining and the timeout counter.
REQ-030 Reset values SHALL be: cmd_ready=1, in_ready=0, out_valid=0, out_hash=0, out_error=0, all core_* outputs 0.
REQ-031 A reset during FEED or REQ SHALL discard the message; no out_valid for it.

Structure
REQ-032 Shared package xxhash32_pkg SHALL hold WORD_SIZE=32, COUNT_W=16 and the state enum typedef.
REQ-033 No sub-module SHALL be used; the parent instantiates xxhash32_sequencer beside the xxhash32 core.

Verification (bench instantiates the sequencer plus the xxhash32 core)
REQ-034 Seed 0, count 0 -> SEED then REQ, no add_to_hash pulses; out_hash=0x02CC5D05, out_error=0.
REQ-035 Seed 0x1, count 4, words streamed back-to-back -> core_add_to_hash high for exactly 4 consecutive cycles starting one cycle after the first handshake; out_hash equals the software reference.
REQ-036 Same message as REQ-035 with in_valid gaps of 3 cycles -> identical out_hash; core_add_to_hash count is exactly 4.
REQ-037 Core stub never asserts core_hash_ready, TIMEOUT_CYCLES=16 -> out_valid exactly 16 cycles after REQ entry, with out_error=1 and out_hash=0.
REQ-038 out_ready held low for 10 cycles in DONE -> outputs stable and cmd_ready=0 throughout; cmd_ready=1 the cycle after acceptance.
REQ-039 rst_n low mid-FEED (word 2 of 4) -> next cycle IDLE with reset values; a new command then hashes correctly.
